pinky_exec_stage: RTL

Parametrised execute/memory stage for the PinKY pipeline, sitting between operand fetch (register read, op2 build) and write-back. It replaces the fixed 16-bit, always-advancing ALU stage. New features:
- valid/ready handshakes on both sides
- configurable word width and data-memory depth
- multi-cycle multiplier that back-pressures the front of the pipe
- signed shift and compare semantics
- Z-flag update for `S`-condition instructions

---
 rtl/pinky_pkg.sv | 37 +++
 rtl/pinky_exec_stage_if.sv | 36 +++
 rtl/pinky_mul_unit.sv | 41 ++++
 rtl/pinky_exec_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pinky_pkg.sv
// pinky_pkg: constants shared by the PinKY fetch, decode and execute stages.
//   - opcode encoding (OPNOP .. OPPRE), 5 bits
//   - condition codes (CC_AL, CC_S, CC_NE, CC_EQ), 2 bits
//   - default datapath word width
//   - execute-stage FSM state type
package pinky_pkg;

    localparam int WORD_W = 16;

    localparam logic [4:0] OPNOP = 5'd0;
    localparam logic [4:0] OPADD = 5'd1;
    localparam logic [4:0] OPSUB = 5'd2;
    localparam logic [4:0] OPAND = 5'd3;
    localparam logic [4:0] OPBIC = 5'd4;
    localparam logic [4:0] OPEOR = 5'd5;
    localparam logic [4:0] OPORR = 5'd6;
    localparam logic [4:0] OPMOV = 5'd7;
    localparam logic [4:0] OPNEG = 5'd8;
    localparam logic [4:0] OPMUL = 5'd9;
    localparam logic [4:0] OPSLT = 5'd10;
    localparam logic [4:0] OPSHA = 5'd11;
    localparam logic [4:0] OPLDR = 5'd12;
    localparam logic [4:0] OPSTR = 5'd13;
    localparam logic [4:0] OPSYS = 5'd14;
    localparam logic [4:0] OPPRE = 5'd15;

    localparam logic [1:0] CC_AL = 2'd0;
    localparam logic [1:0] CC_S  = 2'd1;
    localparam logic [1:0] CC_NE = 2'd2;
    localparam logic [1:0] CC_EQ = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } exec_state_t;

endpackage

// File: rtl/pinky_exec_stage_if.sv
// pinky_exec_stage_if: handshake bundle around the execute stage.
//   Upstream side : in_valid/in_ready, in_op, in_cc, in_dest, in_a, in_b, in_pc
//   Downstream    : out_valid/out_ready, out_value, out_dest, out_wen, out_pc
//   Status        : z_flag
// master = pipeline neighbours (drive in_* and out_ready), slave = the stage.
interface pinky_exec_stage_if #(
    parameter int WIDTH = 16,
    parameter int REG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_op;
    logic [1:0]       in_cc;
    logic [REG_W-1:0] in_dest;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [REG_W-1:0] out_dest;
    logic             out_wen;
    logic [WIDTH-1:0] out_pc;
    logic             z_flag;

    modport master (
        output in_valid, in_op, in_cc, in_dest, in_a, in_b, in_pc, out_ready,
        input  in_ready, out_valid, out_value, out_dest, out_wen, out_pc, z_flag
    );

    modport slave (
        input  in_valid, in_op, in_cc, in_dest, in_a, in_b, in_pc, out_ready,
        output in_ready, out_valid, out_value, out_dest, out_wen, out_pc, z_flag
    );
endinterface

// File: rtl/pinky_mul_unit.sv
// pinky_mul_unit: counter-controlled multiplier.
//   clk, abort (synchronous, cancels any multiply in flight)
//   start, a, b : begin a multiply (operands sampled on start)
//   done        : result valid this cycle (last busy cycle)
//   result      : low WIDTH bits of a*b
// Busy for MUL_CYCLES cycles after start; done marks the last of them.
module pinky_mul_unit #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic             busy;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] prod;

    always_ff @(posedge clk) begin
        if (abort) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= CNT_W'(MUL_CYCLES - 1);
            prod  <= a * b;
        end else if (busy) begin
            if (count == '0) busy <= 1'b0;
            else             count <= count - 1'b1;
        end
    end

    assign done   = busy && (count == '0);
    assign result = prod;
endmodule

// File: rtl/pinky_exec_stage.sv
// pinky_exec_stage: PinKY execute/memory stage.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pinky_exec_stage_if.slave (operand handshake in, result
//                handshake out, z_flag)
// ALU ops and memory ops complete in one cycle; MUL (MUL_CYCLES > 1) parks the
// FSM in BUSY and back-pressures upstream until the multiplier finishes.
module pinky_exec_stage
    import pinky_pkg::*;
#(
    parameter int WIDTH      = WORD_W,
    parameter int DMEM_DEPTH = 65536,
    parameter int MUL_CYCLES = 3,
    parameter int REG_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    pinky_exec_stage_if.slave bus
);
    localparam int              ADDR_W    = $clog2(DMEM_DEPTH);
    localparam bit              MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [WIDTH-1:0] SH_LIM   = WIDTH'(WIDTH);

    logic [WIDTH-1:0] dmem [DMEM_DEPTH];

    exec_state_t      state, state_next;
    logic             rdy, accept, is_mul_multi, load_alu, load_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_val;
    logic [WIDTH-1:0] alu_val;
    logic             alu_wen;

    logic             out_valid_q, out_wen_q, z_q;
    logic [WIDTH-1:0] out_value_q, out_pc_q;
    logic [REG_W-1:0] out_dest_q;

    // Write-back tag of the multiply in flight.
    logic [REG_W-1:0] pend_dest;
    logic [WIDTH-1:0] pend_pc;
    logic             pend_s;

    // B is a signed count: positive shifts left, negative shifts right
    // arithmetically; counts at or beyond the word width saturate.
    function automatic logic [WIDTH-1:0] sha(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] mag;
        mag = '0 - b;
        if (!b[WIDTH-1])
            sha = (b >= SH_LIM) ? '0 : (a << b);
        else
            sha = (mag >= SH_LIM) ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> mag);
    endfunction

    assign is_mul_multi = MUL_MULTI && (bus.in_op == OPMUL);
    assign accept       = bus.in_valid && rdy;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && is_mul_multi) state_next = ST_BUSY;
            ST_BUSY: if (mul_done)               state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs. The result register is always empty while BUSY because
    // a MUL is only accepted when the old result retires on the same edge.
    always_comb begin
        rdy      = 1'b0;
        load_alu = 1'b0;
        load_mul = 1'b0;
        case (state)
            ST_IDLE: begin
                rdy      = !out_valid_q || bus.out_ready;
                load_alu = bus.in_valid && rdy && !is_mul_multi;
            end
            ST_BUSY: load_mul = mul_done;
            default: ;
        endcase
    end

    always_comb begin
        alu_val = '0;
        alu_wen = 1'b1;
        case (bus.in_op)
            OPADD: alu_val = bus.in_a + bus.in_b;
            OPSUB: alu_val = bus.in_a - bus.in_b;
            OPAND: alu_val = bus.in_a & bus.in_b;
            OPBIC: alu_val = bus.in_a & ~bus.in_b;
            OPEOR: alu_val = bus.in_a ^ bus.in_b;
            OPORR: alu_val = bus.in_a | bus.in_b;
            OPMOV: alu_val = bus.in_b;
            OPNEG: alu_val = '0 - bus.in_b;
            OPMUL: alu_val = bus.in_a * bus.in_b;
            OPSLT: alu_val = {{(WIDTH-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
            OPSHA: alu_val = sha(bus.in_a, bus.in_b);
            OPLDR: alu_val = dmem[bus.in_b[ADDR_W-1:0]];
            OPSTR: begin
                alu_val = bus.in_b;
                alu_wen = 1'b0;
            end
            default: alu_wen = 1'b0;
        endcase
    end

    // Stores commit at their accept edge so an LDR right behind sees them.
    always_ff @(posedge clk) begin
        if (!reset && accept && bus.in_op == OPSTR)
            dmem[bus.in_a[ADDR_W-1:0]] <= bus.in_b;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pend_dest <= bus.in_dest;
            pend_pc   <= bus.in_pc;
            pend_s    <= (bus.in_cc == CC_S);
        end
    end

    pinky_mul_unit #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk    (clk),
        .abort  (reset),
        .start  (accept && is_mul_multi),
        .a      (bus.in_a),
        .b      (bus.in_b),
        .done   (mul_done),
        .result (mul_val)
    );

    // Result register: holds while out_valid && !out_ready; a new load and a
    // retire on the same edge simply overwrite.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_dest_q  <= '0;
            out_wen_q   <= 1'b0;
            out_pc_q    <= '0;
            z_q         <= 1'b0;
        end else if (load_alu) begin
            out_valid_q <= 1'b1;
            out_value_q <= alu_val;
            out_dest_q  <= bus.in_dest;
            out_wen_q   <= alu_wen;
            out_pc_q    <= bus.in_pc;
            if (bus.in_cc == CC_S && alu_wen) z_q <= (alu_val == '0);
        end else if (load_mul) begin
            out_valid_q <= 1'b1;
            out_value_q <= mul_val;
            out_dest_q  <= pend_dest;
            out_wen_q   <= 1'b1;
            out_pc_q    <= pend_pc;
            if (pend_s) z_q <= (mul_val == '0);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;
    assign bus.out_dest  = out_dest_q;
    assign bus.out_wen   = out_wen_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.z_flag    = z_q;
endmodule
